// File: rtl/mux_deco_ff.sv
// Sticky capture of the RTC engine "done" indications with a port_id decoder
// that reads flags back to the PicoBlaze or clears them; output is registered.
module mux_deco_ff (
    input  logic       clk,
    input  logic       rst,
    input  logic       listo,
    input  logic       listo_lee,
    input  logic       listo_escribe,
    input  logic [7:0] seleccion,
    output logic [7:0] salida_picoblaze
);

    logic       r_flag_l, r_flag_r, r_flag_w;
    logic       r_prev_l, r_prev_r, r_prev_w;
    logic [7:0] r_out_q;

    logic       w_rise_l, w_rise_r, w_rise_w;
    logic       w_clr_l, w_clr_r, w_clr_w;
    logic [7:0] w_data;

    // prev starts at 0 after reset, so an input already high reports a rise.
    assign w_rise_l = listo         & ~r_prev_l;
    assign w_rise_r = listo_lee     & ~r_prev_r;
    assign w_rise_w = listo_escribe & ~r_prev_w;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_data  = 8'h00;
        w_clr_l = 1'b0;
        w_clr_r = 1'b0;
        w_clr_w = 1'b0;
        case (seleccion)
            8'h01: w_data = {7'b0, r_flag_l};
            8'h02: w_data = {7'b0, r_flag_r};
            8'h03: w_data = {7'b0, r_flag_w};
            8'h04: w_data = {5'b0, r_flag_w, r_flag_r, r_flag_l};
            8'h05: w_clr_l = 1'b1;
            8'h06: w_clr_r = 1'b1;
            8'h07: w_clr_w = 1'b1;
            8'h08: begin
                w_clr_l = 1'b1;
                w_clr_r = 1'b1;
                w_clr_w = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values (data uses old flags).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_l <= 1'b0;
            r_prev_r <= 1'b0;
            r_prev_w <= 1'b0;
            r_flag_l <= 1'b0;
            r_flag_r <= 1'b0;
            r_flag_w <= 1'b0;
            r_out_q  <= 8'h00;
        end else begin
            r_prev_l <= listo;
            r_prev_r <= listo_lee;
            r_prev_w <= listo_escribe;
            r_out_q  <= w_data;

            // A new rise wins over a clear decoded on the same edge.
            if (w_rise_l)     r_flag_l <= 1'b1;
            else if (w_clr_l) r_flag_l <= 1'b0;

            if (w_rise_r)     r_flag_r <= 1'b1;
            else if (w_clr_r) r_flag_r <= 1'b0;

            if (w_rise_w)     r_flag_w <= 1'b1;
            else if (w_clr_w) r_flag_w <= 1'b0;
        end
    end

    assign salida_picoblaze = r_out_q;

endmodule

// File: tb/tb_mux_deco_ff.sv
// Directed vector bench for mux_deco_ff: a table of per-cycle inputs and the
// registered output expected after that edge, plus a few hand-written sequences.
module tb_mux_deco_ff;

    logic       clk;
    logic       rst;
    logic       listo;
    logic       listo_lee;
    logic       listo_escribe;
    logic [7:0] seleccion;
    logic [7:0] salida_picoblaze;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       l;
        logic       r;
        logic       w;
        logic [7:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    mux_deco_ff dut (
        .clk              (clk),
        .rst              (rst),
        .listo            (listo),
        .listo_lee        (listo_lee),
        .listo_escribe    (listo_escribe),
        .seleccion        (seleccion),
        .salida_picoblaze (salida_picoblaze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h", name, got, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge occur, sample 1 time unit later.
    task automatic step(input logic r, input logic l, input logic le, input logic we, input logic [7:0] s);
        @(negedge clk);
        rst           = r;
        listo         = l;
        listo_lee     = le;
        listo_escribe = we;
        seleccion     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic l, input logic le, input logic we,
                       input logic [7:0] s, input logic [7:0] e);
        vec_t v;
        v.rst = r; v.l = l; v.r = le; v.w = we; v.sel = s; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; listo = 1'b0; listo_lee = 1'b0; listo_escribe = 1'b0; seleccion = 8'h00;

        // Reset for two cycles, then confirm all flags clear.
        add(1, 0,0,0, 8'h00, 8'h00);
        add(1, 0,0,0, 8'h04, 8'h00);
        add(0, 0,0,0, 8'h04, 8'h00);
        // Sequential set, five cycles apart, held high.
        add(0, 1,0,0, 8'h04, 8'h00);
        add(0, 1,0,0, 8'h04, 8'h01);
        add(0, 1,0,0, 8'h04, 8'h01);
        add(0, 1,0,0, 8'h04, 8'h01);
        add(0, 1,0,0, 8'h04, 8'h01);
        add(0, 1,1,0, 8'h04, 8'h01);
        add(0, 1,1,0, 8'h04, 8'h03);
        add(0, 1,1,0, 8'h04, 8'h03);
        add(0, 1,1,0, 8'h04, 8'h03);
        add(0, 1,1,0, 8'h04, 8'h03);
        add(0, 1,1,1, 8'h04, 8'h03);
        add(0, 1,1,1, 8'h04, 8'h07);
        add(0, 1,1,1, 8'h01, 8'h01);
        add(0, 1,1,1, 8'h02, 8'h01);
        add(0, 1,1,1, 8'h03, 8'h01);
        add(0, 1,1,1, 8'h04, 8'h07);
        // Individual clear of flag_r.
        add(0, 1,1,1, 8'h06, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h05);
        // Clear-all with levels held: no re-set.
        add(0, 1,1,1, 8'h08, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h00);
        // Drop and re-raise listo.
        add(0, 0,1,1, 8'h04, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h01);
        // Set/clear collision on flag_l.
        add(0, 0,1,1, 8'h05, 8'h00);
        add(0, 0,1,1, 8'h04, 8'h00);
        add(0, 1,1,1, 8'h05, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h01);
        // Held clear code keeps flag_l clear while the level stays high.
        add(0, 1,1,1, 8'h05, 8'h00);
        add(0, 1,1,1, 8'h05, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h00);
        // Set all flags again, then unmapped selectors leave them intact.
        add(0, 0,0,0, 8'h04, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h00);
        add(0, 1,1,1, 8'h09, 8'h00);
        add(0, 1,1,1, 8'h00, 8'h00);
        add(0, 1,1,1, 8'hFF, 8'h00);
        add(0, 1,1,1, 8'h04, 8'h07);
        // Mid-run reset discards flags.
        add(1, 1,1,1, 8'h04, 8'h00);
        add(0, 0,0,0, 8'h04, 8'h00);
        // Input already high across reset release is captured.
        add(1, 1,0,0, 8'h04, 8'h00);
        add(0, 1,0,0, 8'h04, 8'h00);
        add(0, 1,0,0, 8'h04, 8'h01);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].w, vecs[i].sel);
            check($sformatf("vec%0d", i), salida_picoblaze, vecs[i].exp);
        end

        // Single-cycle pulse on listo_lee is held as a sticky flag.
        step(1, 0,0,0, 8'h04);
        step(0, 0,1,0, 8'h02);
        check("pulse_edge1", salida_picoblaze, 8'h00);
        step(0, 0,0,0, 8'h02);
        check("pulse_edge2", salida_picoblaze, 8'h01);
        for (int k = 0; k < 3; k++) begin
            step(0, 0,0,0, 8'h04);
            check($sformatf("pulse_hold%0d", k), salida_picoblaze, 8'h02);
        end

        // Selector change is seen one edge later; clear of flag_w only.
        step(0, 0,0,1, 8'h03);
        check("w_rise_edge1", salida_picoblaze, 8'h00);
        step(0, 0,0,1, 8'h03);
        check("w_rise_edge2", salida_picoblaze, 8'h01);
        step(0, 0,0,1, 8'h07);
        check("w_clear_data", salida_picoblaze, 8'h00);
        step(0, 0,0,1, 8'h04);
        check("w_cleared", salida_picoblaze, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
